bcd_to_bin_convertor: RTL and testbench

//   Converts packed BCD digits (default 2 digits, 00-99) to an unsigned binary value using

---
 rtl/bcd_to_bin_convertor.sv | 101 ++++++++++
 tb/tb_bcd_to_bin_convertor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_convertor.sv
// Packed BCD to unsigned binary converter using reverse double dabble.
// One right shift per cycle with a subtract-3 correction on every BCD digit >= 8.
module bcd_to_bin_convertor #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4*DIGITS-1:0]   i_bcd_data,
    input  logic                  i_load,
    output logic [BIN_W-1:0]      o_data,
    output logic                  o_valid,
    output logic                  o_busy,
    output logic                  o_error
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SCR_W = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SCR_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;
    logic [SCR_W-1:0]   w_shifted;
    logic [SCR_W-1:0]   w_adjusted;
    logic [DIGITS-1:0]  w_digit_bad;
    logic               w_last_shift;

    // Scratch layout: BCD digits in the upper bits, binary result builds up in the lower BIN_W bits.
    assign w_shifted                 = r_scratch >> 1;
    assign w_adjusted[BIN_W-1:0]     = w_shifted[BIN_W-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_dig;
            assign w_dig            = w_shifted[BIN_W + 4*gi +: 4];
            assign w_adjusted[BIN_W + 4*gi +: 4] = (w_dig >= 4'd8) ? (w_dig - 4'd3) : w_dig;
            assign w_digit_bad[gi]  = (i_bcd_data[4*gi +: 4] > 4'd9);
        end
    endgenerate

    assign w_last_shift = (r_state == S_SHIFT) && (r_count == CNT_W'(1));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A new load restarts the conversion, even on the final shift edge.
                if (i_load) begin
                    w_state_next = S_SHIFT;
                end else if (w_last_shift) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_scratch <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            o_busy  <= (w_state_next == S_SHIFT);
            o_valid <= 1'b0;
            if (i_load) begin
                r_scratch <= {i_bcd_data, {BIN_W{1'b0}}};
                r_count   <= CNT_W'(BIN_W);
                r_err     <= |w_digit_bad;
            end else if (r_state == S_SHIFT) begin
                r_scratch <= w_adjusted;
                r_count   <= r_count - CNT_W'(1);
                if (w_last_shift) begin
                    o_data  <= r_err ? '0 : w_adjusted[BIN_W-1:0];
                    o_error <= r_err;
                    o_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_convertor.sv
// Self-checking bench for bcd_to_bin_convertor: directed cases, restart/reset corners,
// exhaustive valid inputs and random bytes checked against a decimal reference model.
`timescale 1ns/1ps
module tb_bcd_to_bin_convertor;

    localparam int DIGITS = 2;
    localparam int BIN_W  = 8;

    logic                 i_clk;
    logic                 i_rst;
    logic [4*DIGITS-1:0]  i_bcd_data;
    logic                 i_load;
    logic [BIN_W-1:0]     o_data;
    logic                 o_valid;
    logic                 o_busy;
    logic                 o_error;

    int checks = 0;
    int errors = 0;

    bcd_to_bin_convertor #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_bcd_data (i_bcd_data),
        .i_load     (i_load),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_busy     (o_busy),
        .o_error    (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: decimal value of the digits and invalid-digit flag.
    function automatic int model_val(input logic [4*DIGITS-1:0] b);
        int v = 0;
        int w = 1;
        for (int d = 0; d < DIGITS; d++) begin
            v += int'(b[4*d +: 4]) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic logic model_err(input logic [4*DIGITS-1:0] b);
        logic e = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (b[4*d +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge just after the load edge; waits for the completion pulse.
    task automatic wait_result(input string tag, input logic [31:0] exp_data, input logic exp_err);
        int lat = 0;
        chk({tag, " busy_after_load"}, 32'(o_busy), 32'd1);
        for (int c = 1; c <= 20; c++) begin
            @(negedge i_clk);
            if (c == BIN_W - 1) chk({tag, " busy_last_shift"}, 32'(o_busy), 32'd1);
            if (o_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(BIN_W));
        chk({tag, " data"}, 32'(o_data), exp_data);
        chk({tag, " error"}, 32'(o_error), 32'(exp_err));
        chk({tag, " busy_done"}, 32'(o_busy), 32'd0);
        @(negedge i_clk);
        chk({tag, " pulse_width"}, 32'(o_valid), 32'd0);
        chk({tag, " data_hold"}, 32'(o_data), exp_data);
    endtask

    task automatic convert(input logic [4*DIGITS-1:0] bcd);
        string tag;
        logic  e;
        tag = $sformatf("conv_%02h", bcd);
        e   = model_err(bcd);
        @(negedge i_clk);
        i_bcd_data = bcd;
        i_load     = 1'b1;
        @(negedge i_clk);
        i_load = 1'b0;
        wait_result(tag, e ? 32'd0 : 32'(model_val(bcd)), e);
        $display("conv bcd=%02h data=%02h error=%0b", bcd, o_data, o_error);
    endtask

    task automatic no_valid_for(input string tag, input int cycles);
        int seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
        chk({tag, " no_valid"}, 32'(seen), 32'd0);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_load     = 1'b0;
        i_bcd_data = '0;
        repeat (3) @(negedge i_clk);
        chk("reset data", 32'(o_data), 32'd0);
        chk("reset valid", 32'(o_valid), 32'd0);
        chk("reset busy", 32'(o_busy), 32'd0);
        chk("reset error", 32'(o_error), 32'd0);
        i_rst = 1'b0;
        no_valid_for("idle_after_reset", 4);

        // Directed values including the invalid-digit case and its clearing.
        convert(8'h42);
        convert(8'h99);
        convert(8'h00);
        convert(8'h09);
        convert(8'h10);
        convert(8'h1A);
        convert(8'h05);

        // Restart three cycles after a load: only the second conversion reports.
        @(negedge i_clk);
        i_bcd_data = 8'h42;
        i_load     = 1'b1;
        @(negedge i_clk);
        i_load = 1'b0;
        no_valid_for("restart_gap", 2);
        i_bcd_data = 8'h17;
        i_load     = 1'b1;
        @(negedge i_clk);
        i_load = 1'b0;
        wait_result("restart_17", 32'h11, 1'b0);
        $display("restart bcd=17 data=%02h error=%0b", o_data, o_error);

        // Load coinciding with the final shift edge: restart wins, no pulse.
        @(negedge i_clk);
        i_bcd_data = 8'h33;
        i_load     = 1'b1;
        @(negedge i_clk);
        i_load = 1'b0;
        no_valid_for("final_edge_pre", BIN_W - 1);
        i_bcd_data = 8'h64;
        i_load     = 1'b1;
        @(negedge i_clk);
        i_load = 1'b0;
        chk("final_edge valid", 32'(o_valid), 32'd0);
        wait_result("final_edge_64", 32'd64, 1'b0);
        $display("final_edge bcd=64 data=%02h error=%0b", o_data, o_error);

        // Reset in the middle of a conversion.
        @(negedge i_clk);
        i_bcd_data = 8'h55;
        i_load     = 1'b1;
        @(negedge i_clk);
        i_load = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("midreset data", 32'(o_data), 32'd0);
        chk("midreset valid", 32'(o_valid), 32'd0);
        chk("midreset busy", 32'(o_busy), 32'd0);
        chk("midreset error", 32'(o_error), 32'd0);
        no_valid_for("midreset", 12);
        $display("midreset data=%02h busy=%0b", o_data, o_busy);

        // Reset together with load: reset wins, stays idle.
        @(negedge i_clk);
        i_rst      = 1'b1;
        i_load     = 1'b1;
        i_bcd_data = 8'h21;
        @(negedge i_clk);
        i_rst  = 1'b0;
        i_load = 1'b0;
        chk("rst_load busy", 32'(o_busy), 32'd0);
        no_valid_for("rst_load", 12);
        $display("rst_with_load busy=%0b data=%02h", o_busy, o_data);

        // Every valid two-digit BCD input.
        for (int v = 0; v < 100; v++) begin
            logic [7:0] b;
            b = {4'(v / 10), 4'(v % 10)};
            convert(b);
        end

        // Random bytes, including invalid digits.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            convert(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
